// File: rtl/conv_window_sequencer.sv
// Control front-end for the Conv2D3x3 window buffer: loads geometry, gates the
// word stream under backpressure, injects pad flush words and reports done/error.
module conv_window_sequencer #(
  parameter int WORD_WIDTH     = 8,
  parameter int MAX_IMG_WIDTH  = 128,
  parameter int MAX_IMG_HEIGHT = 128,
  parameter int MAX_TRANSFERS  = 512
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic                              i_start,
  input  logic                              i_pad,
  input  logic [WORD_WIDTH-1:0]             i_pad_val,
  input  logic [$clog2(MAX_IMG_WIDTH):0]    i_width,
  input  logic [$clog2(MAX_IMG_HEIGHT):0]   i_height,
  input  logic [$clog2(MAX_TRANSFERS):0]    i_transfers,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_error,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [WORD_WIDTH-1:0]             s_data,
  input  logic                              s_last,
  input  logic                              i_win_ready,
  output logic                              o_wb_load_param,
  output logic                              o_wb_pad,
  output logic [WORD_WIDTH-1:0]             o_wb_pad_val,
  output logic [$clog2(MAX_IMG_WIDTH):0]    o_wb_width,
  output logic [$clog2(MAX_IMG_HEIGHT):0]   o_wb_height,
  output logic [$clog2(MAX_TRANSFERS):0]    o_wb_transfers,
  output logic                              o_wb_valid,
  output logic [WORD_WIDTH-1:0]             o_wb_data,
  input  logic                              i_wb_last_window
);

  localparam int W_W = $clog2(MAX_IMG_WIDTH) + 1;
  localparam int H_W = $clog2(MAX_IMG_HEIGHT) + 1;
  localparam int T_W = $clog2(MAX_TRANSFERS) + 1;
  // Counters sized for the full range of the geometry ports so the product never truncates.
  localparam int PW  = T_W + W_W + H_W;
  localparam int FW  = T_W + W_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_STREAM, ST_FLUSH, ST_DRAIN, ST_DONE
  } state_t;

  state_t                r_state, w_next;
  logic [PW-1:0]         r_words;
  logic [FW-1:0]         r_flush;
  logic [1:0]            r_drain;
  logic                  r_lw_seen;
  logic                  r_error;
  logic                  r_pad;
  logic [WORD_WIDTH-1:0] r_pad_val;
  logic [W_W-1:0]        r_width;
  logic [H_W-1:0]        r_height;
  logic [T_W-1:0]        r_trans;

  logic                  w_hs, w_fadv, w_bad_cfg, w_set_err, w_last_word;
  logic [PW-1:0]         w_prod;
  logic [FW-1:0]         w_fprod;

  assign w_bad_cfg   = (i_width < W_W'(3)) || (i_height < H_W'(3)) || (i_transfers == '0);
  assign w_hs        = (r_state == ST_STREAM) && s_valid && i_win_ready;
  // A last-window flag wins over a ready advance in the same cycle: nothing more is written.
  assign w_fadv      = (r_state == ST_FLUSH) && i_win_ready && !i_wb_last_window;
  assign w_last_word = (r_words == PW'(1));
  assign w_prod      = PW'(r_trans) * PW'(r_width) * PW'(r_height);
  assign w_fprod     = FW'(r_trans) * (FW'(r_width) + FW'(1));

  assign s_ready         = (r_state == ST_STREAM) && i_win_ready;
  assign o_wb_valid      = w_hs || w_fadv;
  assign o_wb_data       = (r_state == ST_FLUSH) ? r_pad_val : s_data;
  assign o_wb_load_param = (r_state == ST_LOAD);
  assign o_busy          = (r_state != ST_IDLE);
  assign o_done          = (r_state == ST_DONE);
  assign o_error         = r_error;
  assign o_wb_pad        = r_pad;
  assign o_wb_pad_val    = r_pad_val;
  assign o_wb_width      = r_width;
  assign o_wb_height     = r_height;
  assign o_wb_transfers  = r_trans;

  always_comb begin
    w_next    = r_state;
    w_set_err = 1'b0;
    case (r_state)
      ST_IDLE: if (i_start) begin
        w_next    = w_bad_cfg ? ST_DONE : ST_LOAD;
        w_set_err = w_bad_cfg;
      end
      ST_LOAD: w_next = ST_STREAM;
      ST_STREAM: if (w_hs) begin
        if (w_last_word) begin
          w_set_err = !s_last;
          w_next    = (r_flush != '0) ? ST_FLUSH : ST_DRAIN;
        end else if (s_last) begin
          w_set_err = 1'b1;
          w_next    = ST_DONE;
        end
      end
      ST_FLUSH: begin
        if (i_wb_last_window) begin
          w_next = ST_DONE;
        end else if (w_fadv && (r_flush == FW'(1))) begin
          w_set_err = 1'b1;
          w_next    = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (r_lw_seen || i_wb_last_window) begin
          w_next = ST_DONE;
        end else if (r_drain == 2'd3) begin
          w_set_err = 1'b1;
          w_next    = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_words   <= '0;
      r_flush   <= '0;
      r_drain   <= '0;
      r_lw_seen <= 1'b0;
      r_error   <= 1'b0;
      r_pad     <= 1'b0;
      r_pad_val <= '0;
      r_width   <= '0;
      r_height  <= '0;
      r_trans   <= '0;
    end else begin
      if ((r_state == ST_IDLE) && i_start) begin
        r_pad     <= i_pad;
        r_pad_val <= i_pad_val;
        r_width   <= i_width;
        r_height  <= i_height;
        r_trans   <= i_transfers;
      end
      if (w_set_err)                             r_error <= 1'b1;
      else if ((r_state == ST_IDLE) && i_start)  r_error <= 1'b0;
      if (r_state == ST_LOAD) begin
        r_words   <= w_prod;
        r_flush   <= r_pad ? w_fprod : '0;
        r_drain   <= '0;
        r_lw_seen <= 1'b0;
      end
      // The buffer may raise last-window on the final stream word itself; remember it for DRAIN.
      if (w_hs) begin
        r_words <= r_words - PW'(1);
        if (w_last_word) r_lw_seen <= i_wb_last_window;
      end
      if (w_fadv)                r_flush <= r_flush - FW'(1);
      if (r_state == ST_DRAIN)   r_drain <= r_drain + 2'd1;
    end
  end

endmodule
